// File: rtl/rom_frame_streamer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rom_frame_streamer_pkg : shared FSM type and default sizes (rev 1.0)
// ----------------------------------------------------------------------------
package rom_frame_streamer_pkg;

   localparam int DEFAULT_DATA_W = 24;
   localparam int DEFAULT_ADDR_W = 13;
   localparam int DEFAULT_DEPTH  = 4800;
   localparam int FRAME_CNT_W    = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/rom_frame_streamer_skid_buffer2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// skid_buffer2 : two-entry in-order buffer, entry 0 is always the head (rev 1.0)
// ----------------------------------------------------------------------------
module skid_buffer2 import rom_frame_streamer_pkg::*; #(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic [1:0]        occ
);

   logic [DATA_W-1:0] ent0_q, ent0_d;
   logic [DATA_W-1:0] ent1_q, ent1_d;
   logic [1:0]        occ_q, occ_d;
   logic              do_pop;

   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      occ_d  = occ_q;
      do_pop = pop && (occ_q != 2'd0);
      case ({push, do_pop})
         2'b10: begin
            if (occ_q != 2'd2) begin
               if (occ_q == 2'd0) ent0_d = push_data;
               else               ent1_d = push_data;
               occ_d = occ_q + 2'd1;
            end
         end
         2'b01: begin
            ent0_d = ent1_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            // Simultaneous push/pop keeps occupancy; the new word lands behind any survivor.
            if (occ_q == 2'd1) begin
               ent0_d = push_data;
            end else begin
               ent0_d = ent1_q;
               ent1_d = push_data;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent0_q <= '0;
         ent1_q <= '0;
         occ_q  <= 2'd0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         occ_q  <= occ_d;
      end
   end

   assign head = ent0_q;
   assign occ  = occ_q;

endmodule
`default_nettype wire

// File: rtl/rom_frame_streamer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rom_frame_streamer : streams a wrapped ROM address window into a FIFO (rev 1.0)
// ----------------------------------------------------------------------------
module rom_frame_streamer import rom_frame_streamer_pkg::*; #(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DEPTH  = DEFAULT_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   loop_en,
   input  logic                   abort,
   input  logic [ADDR_W-1:0]      base_addr,
   input  logic [ADDR_W-1:0]      frame_len,
   output logic [ADDR_W-1:0]      rom_addr,
   input  logic [DATA_W-1:0]      rom_data,
   input  logic                   fifo_full,
   output logic                   wen,
   output logic [DATA_W-1:0]      data_out,
   output logic                   busy,
   output logic                   done,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_e                 state_q, state_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [ADDR_W-1:0]      base_q, base_d;
   logic [ADDR_W-1:0]      len_q, len_d;
   logic [ADDR_W-1:0]      issued_q, issued_d;
   logic                   inflight_q, inflight_d;
   logic                   aborted_q, aborted_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

   logic       rom_rd;
   logic       pop;
   logic       reads_left;
   logic [1:0] occ;
   logic [2:0] pending;

   // Words that will occupy the buffer next cycle if nothing new is issued.
   assign pending    = 3'(occ) + 3'(inflight_q) - 3'(pop);
   assign reads_left = (issued_q != len_q);
   assign rom_rd     = (state_q == ST_RUN) && !abort && reads_left && (pending < 3'd2);
   assign wen        = (occ != 2'd0) && !fifo_full;
   assign pop        = wen;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      base_d      = base_q;
      len_d       = len_q;
      issued_d    = issued_q;
      inflight_d  = rom_rd;
      aborted_d   = aborted_q;
      frame_cnt_d = frame_cnt_q;

      if (rom_rd) begin
         addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
         issued_d = issued_q + ADDR_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d   = ST_RUN;
               base_d    = base_addr;
               len_d     = frame_len;
               addr_d    = base_addr;
               issued_d  = '0;
               aborted_d = 1'b0;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d   = ST_DRAIN;
               aborted_d = 1'b1;
            end else if (!reads_left || (rom_rd && (issued_q + ADDR_W'(1) == len_q))) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((occ == 2'd0) && !inflight_q) begin
               state_d = aborted_q ? ST_IDLE : ST_FIN;
            end
         end
         ST_FIN: begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            if (loop_en && !abort) begin
               state_d  = ST_RUN;
               addr_d   = base_q;
               issued_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         base_q      <= '0;
         len_q       <= '0;
         issued_q    <= '0;
         inflight_q  <= 1'b0;
         aborted_q   <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         base_q      <= base_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         inflight_q  <= inflight_d;
         aborted_q   <= aborted_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   skid_buffer2 #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_data (rom_data),
      .pop       (pop),
      .head      (data_out),
      .occ       (occ)
   );

   assign rom_addr  = addr_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_FIN);
   assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_frame_streamer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rom_frame_streamer : randomized bench with a word-queue reference model (rev 1.0)
// ----------------------------------------------------------------------------
module tb_rom_frame_streamer;

   localparam int DATA_W = 24;
   localparam int ADDR_W = 13;
   localparam int DEPTH  = 4800;

   logic              clk = 1'b0;
   logic              rst;
   logic              start, loop_en, abort, fifo_full;
   logic [ADDR_W-1:0] base_addr, frame_len, rom_addr;
   logic [DATA_W-1:0] rom_data, data_out;
   logic              wen, busy, done;
   logic [15:0]       frame_cnt;

   always #5 clk = ~clk;

   rom_frame_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .loop_en(loop_en), .abort(abort),
      .base_addr(base_addr), .frame_len(frame_len), .rom_addr(rom_addr),
      .rom_data(rom_data), .fifo_full(fifo_full), .wen(wen), .data_out(data_out),
      .busy(busy), .done(done), .frame_cnt(frame_cnt)
   );

   // Synchronous ROM: data for an address appears one cycle later.
   logic [DATA_W-1:0] rom [0:DEPTH-1];
   always @(posedge clk) rom_data <= (int'(rom_addr) < DEPTH) ? rom[rom_addr] : '0;

   int n_cmp = 0, n_err = 0;
   int cyc = 0;
   int words_seen = 0, done_seen = 0, exp_frames = 0;
   int first_wen_cyc = -1, last_wen_cyc = -1;
   logic [DATA_W-1:0] exp_q[$];
   int                exp_end_q[$];
   int  full_pct = 0;
   bit  full_force = 1'b0;
   logic [15:0] prev_cnt;
   logic        prev_done;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      fifo_full = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         fifo_full = full_force ? 1'b1 : ($urandom_range(0, 99) < full_pct);
      end
   end

   // Compare process: every accepted word must be the next expected word,
   // and every done must land exactly where a frame's word count ends.
   always @(negedge clk) begin
      if (!rst) begin
         prev_cnt  = '0;
         prev_done = 1'b0;
      end else begin
         check("frame_cnt_step", frame_cnt, prev_cnt + 16'(prev_done));
         if (wen) begin
            check("wen_while_full", fifo_full, 0);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL extra_word: got data %0h, expected no word (cycle %0d)", data_out, cyc);
            end else begin
               check("data_out", data_out, exp_q.pop_front());
            end
            if (first_wen_cyc < 0) first_wen_cyc = cyc;
            last_wen_cyc = cyc;
            words_seen++;
         end
         if (done) begin
            done_seen++;
            if (exp_end_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
            end else begin
               check("done_at_word", words_seen, exp_end_q.pop_front());
            end
         end
         prev_cnt  = frame_cnt;
         prev_done = done;
      end
   end

   task automatic expect_frames(input int base, input int len, input int nframes);
      for (int f = 0; f < nframes; f++) begin
         for (int i = 0; i < len; i++) exp_q.push_back(rom[(base + i) % DEPTH]);
         exp_end_q.push_back(words_seen + exp_q.size());
      end
   endtask

   task automatic pulse_start(input int base, input int len);
      base_addr = ADDR_W'(base);
      frame_len = ADDR_W'(len);
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      check({name, "_idle"}, busy, 0);
   endtask

   task automatic wait_words(input int target, input int budget);
      int n = 0;
      while (words_seen < target && n < budget) begin
         tick();
         n++;
      end
   endtask

   // Runs one frame whose expected words are already queued.
   task automatic do_frame(input int base, input int len, input int pct, input string name);
      int w0 = words_seen;
      int d0 = done_seen;
      full_pct = pct;
      pulse_start(base, len);
      wait_idle(name, len * 10 + 50);
      check({name, "_words"}, words_seen - w0, len);
      check({name, "_done"}, done_seen - d0, 1);
      exp_frames++;
      check({name, "_frame_cnt"}, frame_cnt, exp_frames);
   endtask

   task automatic run_frame(input int base, input int len, input int pct, input string name);
      expect_frames(base, len, 1);
      do_frame(base, len, pct, name);
   endtask

   initial begin
      int s, b, w0, d0, n;
      int wrap_addrs[4];
      int pcts[4];
      wrap_addrs = '{4798, 4799, 0, 1};
      pcts       = '{0, 25, 50, 75};
      rst = 1'b0; start = 1'b0; loop_en = 1'b0; abort = 1'b0;
      base_addr = '0; frame_len = '0;
      for (int i = 0; i < DEPTH; i++) rom[i] = DATA_W'($urandom);
      repeat (3) @(posedge clk);
      #1;
      check("reset_rom_addr", rom_addr, 0);
      check("reset_wen", wen, 0);
      check("reset_data_out", data_out, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_frame_cnt", frame_cnt, 0);
      rst = 1'b1;
      tick();

      // Whole ROM, no backpressure: fixed latency and one word per cycle.
      first_wen_cyc = -1;
      s = cyc;
      run_frame(0, DEPTH, 0, "full_frame");
      check("first_wen_latency", first_wen_cyc - s, 3);
      check("full_frame_gapless", last_wen_cyc - first_wen_cyc, DEPTH - 1);
      check("full_frame_cnt_literal", frame_cnt, 1);

      // Address wrap, expected words from a literal address list.
      for (int i = 0; i < 4; i++) exp_q.push_back(rom[wrap_addrs[i]]);
      exp_end_q.push_back(words_seen + 4);
      do_frame(4798, 4, 0, "wrap");

      run_frame($urandom_range(0, DEPTH - 1), 100, 50, "throttled");
      run_frame(123, 0, 0, "empty_frame");

      // Start together with abort is ignored.
      full_pct = 0;
      d0 = done_seen;
      base_addr = 13'd5; frame_len = 13'd5;
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      repeat (3) begin
         check("start_abort_busy", busy, 0);
         tick();
      end
      check("start_abort_no_done", done_seen - d0, 0);

      // A second start while busy must not disturb the running frame.
      expect_frames(100, 30, 1);
      w0 = words_seen; d0 = done_seen;
      pulse_start(100, 30);
      repeat (4) tick();
      check("busy_mid_frame", busy, 1);
      pulse_start(2000, 7);
      wait_idle("restart_ignored", 400);
      check("restart_ignored_words", words_seen - w0, 30);
      check("restart_ignored_done", done_seen - d0, 1);
      exp_frames++;

      // Loop mode: clearing loop_en during the third frame stops after it.
      full_pct = 25;
      b = $urandom_range(0, DEPTH - 1);
      w0 = words_seen; d0 = done_seen;
      expect_frames(b, 10, 3);
      loop_en = 1'b1;
      pulse_start(b, 10);
      n = 0;
      while (done_seen < d0 + 2 && n < 500) begin
         tick();
         n++;
      end
      check("loop_second_done", done_seen - d0, 2);
      loop_en = 1'b0;
      wait_idle("loop", 500);
      check("loop_words", words_seen - w0, 30);
      check("loop_done", done_seen - d0, 3);
      exp_frames += 3;
      check("loop_frame_cnt", frame_cnt, exp_frames);

      // Abort under held backpressure: at most two buffered words drain out.
      full_pct = 0;
      b = $urandom_range(0, DEPTH - 1);
      w0 = words_seen; d0 = done_seen;
      for (int i = 0; i < 50; i++) exp_q.push_back(rom[(b + i) % DEPTH]);
      pulse_start(b, 50);
      wait_words(w0 + 5, 200);
      check("abort_reached_5", words_seen - w0, 5);
      full_force = 1'b1;
      abort = 1'b1;
      repeat (10) tick();
      check("abort_hold_no_words", words_seen - w0, 5);
      full_force = 1'b0;
      wait_idle("abort", 100);
      abort = 1'b0;
      check("abort_extra_le2", (words_seen - w0 - 5) <= 2, 1);
      check("abort_no_done", done_seen - d0, 0);
      check("abort_frame_cnt", frame_cnt, exp_frames);
      exp_q.delete();
      tick();

      for (int k = 0; k < 6; k++)
         run_frame($urandom_range(0, DEPTH - 1), $urandom_range(1, 150),
                   pcts[$urandom_range(0, 3)], "rand_frame");

      // Reset in the middle of a frame, then restart from the same base.
      full_pct = 0;
      b = $urandom_range(0, DEPTH - 1);
      w0 = words_seen;
      expect_frames(b, 50, 1);
      pulse_start(b, 50);
      wait_words(w0 + 20, 200);
      rst = 1'b0;
      #1;
      check("midrst_rom_addr", rom_addr, 0);
      check("midrst_wen", wen, 0);
      check("midrst_data_out", data_out, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_frame_cnt", frame_cnt, 0);
      exp_q.delete();
      exp_end_q.delete();
      exp_frames = 0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_wen", wen, 0);
      check("post_rst_busy", busy, 0);
      tick();
      run_frame(b, 50, 0, "post_rst_frame");
      check("post_rst_cnt_literal", frame_cnt, 1);

      repeat (5) tick();
      check("leftover_words", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
